i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
Single-byte I2C bus master. It generates SCL and START/STOP conditions and drives SDA through an enable/value pair that is wired open-drain at the top level. Each transaction sends a 7-bit address plus R/W, then writes one byte to, or reads one byte from, the addressed slave at a fixed bit rate derived from the system clock. It is the initiator counterpart of the team's I2C slave block and uses the same four-phase bit timing.

Parameters:
CLK_FREQ, 125000000, system clock frequency in Hz.
I2C_FREQ, 312500, SCL frequency in Hz.
BIT_CYCLES, CLK_FREQ/I2C_FREQ (400), clk cycles per SCL bit period.
QUARTER, BIT_CYCLES/4 (100), clk cycles per phase.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high. Clock is clk.
start  in  1  request a transaction; sampled only in IDLE.
rw  in  1  1 = read, 0 = write; latched on accepted start.
addr  in  7  slave address; latched on accepted start.
din  in  8  write data; latched on accepted start.
sda_in  in  1  resolved SDA bus level.
scl  out  1  SCL.
sda_en  out  1  1 = master drives SDA; 0 = released (bus pulled high).
sda_out  out  1  SDA value while sda_en=1.
dout  out  8  byte received in a read.
busy  out  1  high from start acceptance until done.
ack_err  out  1  slave NACKed the address or write data.
done  out  1  one-cycle pulse at end of transaction.

Behaviour:
- Bit timer: cnt runs 0..BIT_CYCLES-1 and wraps; phase = cnt/QUARTER (0..3). cnt is held at 0 in IDLE.
- SCL during data, ack and STOP bits: low in phases 0-1, high in phases 2-3.
- Master changes SDA only at cnt==QUARTER (SCL low) and samples sda_in at cnt==2*QUARTER (first SCL-high cycle).
- Reset values: scl=1, sda_en=0, sda_out=1, dout=0, busy=0, ack_err=0, done=0, state=IDLE, cnt=0.
- IDLE:
  - start=1 latches addr, rw and din, sets busy=1, clears ack_err, and moves to START.
  - start while busy is ignored.
- START (1 bit period): scl=1 throughout; sda_en=1; sda_out=1 in phases 0-1, 0 in phases 2-3.
- WRITE_ADDR (8 periods): shifts out {addr,rw} MSB first.
- ADDR_ACK (1 period): sda_en=0; sample sda_in.
  - sampled 1: ack_err=1, go to STOP.
  - sampled 0 with rw=0: go to WRITE_DATA.
  - sampled 0 with rw=1: go to READ_DATA.
- WRITE_DATA (8 periods): shifts out din MSB first.
- DATA_ACK (1 period): sda_en=0; sample sda_in; 1 sets ack_err=1; then go to STOP.
- READ_DATA (8 periods): sda_en=0; each sample shifts left into a register; dout loads the full byte at the end of the 8th period.
- MASTER_NACK (1 period): sda_en=0 (NACK, single byte); then go to STOP.
- STOP (1 period):
  - sda_en=1, sda_out=0 in phases 0-2.
  - scl low in phases 0-1, high in phases 2-3.
  - sda_en=0 at cnt==3*QUARTER, giving a rising SDA while SCL is high.
  - At cnt==BIT_CYCLES-1: done=1 for one cycle, busy=0, return to IDLE.
- State transitions happen only at cnt==BIT_CYCLES-1. Bit counter is 0..7 and is cleared on leaving each byte state.
- Latency, with the accepted start cycle = T:
  - Full transaction (START + 8 + ack + 8 + ack + STOP = 20 periods): done at T+1+20*BIT_CYCLES, i.e. T+8001 at defaults.
  - Address NACK (11 periods): done at T+1+4400.
- ack_err holds until the next accepted start. dout holds until the next completed read.
- start asserted in the same cycle as done is ignored; a new start is accepted only from the following cycle.
- rst mid-transaction returns everything to reset values immediately. No STOP is generated.
- Latched inputs do not change during a transaction, regardless of port activity.

Test Plan:
- Write: addr=0x2A, rw=0, din=0xA5; slave model ACKs both bytes.
  -> SDA bits sampled at SCL rising edges = 0x54 then 0xA5.
  -> ack_err=0; done pulse at T+8001; busy high T+1..T+8000.
- Read: addr=0x15, rw=1; slave model ACKs, then drives 0x3C MSB first.
  -> address bits = 0x2B; master leaves SDA released during the 9th bit after the data byte.
  -> dout=0x3C, ack_err=0 at done.
- Address NACK: sda_in held 1.
  -> ack_err=1; no data bits; STOP emitted; done at T+4401.
- Write data NACK: address ACKed, data bit sampled 1.
  -> ack_err=1, done at T+8001; next accepted start clears ack_err.
- Start pulsed at T+500 while busy, and again in the done cycle.
  -> both ignored; exactly one transaction.
- rst asserted mid-transaction (cnt=150 of 3rd address bit).
  -> scl=1, sda_en=0, busy=0, done=0 immediately; a new start then runs a clean transaction.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master (7-bit address + R/W, one data byte written or read)
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             request a transaction (accepted only in IDLE, not in the done cycle)
//   rw, addr, din     direction, slave address and write byte, latched on accepted start
//   sda_in            resolved SDA bus level
//   scl               SCL output
//   sda_en, sda_out   open-drain SDA drive: sda_out is driven only while sda_en=1
//   dout              byte received by the last completed read
//   busy              transaction in progress
//   ack_err           slave NACKed the address or the write data
//   done              one-cycle pulse at the end of a transaction
module i2c_master #(
    parameter int CLK_FREQ = 125000000,
    parameter int I2C_FREQ = 312500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_en,
    output logic       sda_out,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ack_err,
    output logic       done
);
    localparam int BIT_CYCLES = CLK_FREQ / I2C_FREQ;
    localparam int QUARTER = BIT_CYCLES / 4;
    localparam int CW = $clog2(BIT_CYCLES);

    typedef enum logic [3:0] {
        IDLE, START, WRITE_ADDR, ADDR_ACK, WRITE_DATA, DATA_ACK, READ_DATA, MASTER_NACK, STOP
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx, rx, din_l;
    logic rw_l;
    logic q_end, h_end, smp, t_end, last;

    // Outputs are registered, so each event fires one cycle early to appear at its phase boundary.
    assign q_end = cnt == CW'(QUARTER - 1);
    assign h_end = cnt == CW'(2 * QUARTER - 1);
    assign smp = cnt == CW'(2 * QUARTER);
    assign t_end = cnt == CW'(3 * QUARTER - 1);
    assign last = cnt == CW'(BIT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            tx <= '0;
            rx <= '0;
            din_l <= '0;
            rw_l <= 1'b0;
            scl <= 1'b1;
            sda_en <= 1'b0;
            sda_out <= 1'b1;
            dout <= '0;
            busy <= 1'b0;
            ack_err <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
            if (state != IDLE && h_end) scl <= 1'b1;
            // STOP ends with SCL high, so it is the only bit that does not pull SCL low at the wrap.
            if (state != IDLE && state != STOP && last) scl <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        tx <= {addr, rw};
                        rw_l <= rw;
                        din_l <= din;
                        busy <= 1'b1;
                        ack_err <= 1'b0;
                        sda_en <= 1'b1;
                        sda_out <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (h_end) sda_out <= 1'b0;
                    if (last) state <= WRITE_ADDR;
                end
                WRITE_ADDR, WRITE_DATA: begin
                    if (q_end) begin
                        sda_en <= 1'b1;
                        sda_out <= tx[7];
                    end
                    if (last) begin
                        tx <= {tx[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= (state == WRITE_ADDR) ? ADDR_ACK : DATA_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (q_end) sda_en <= 1'b0;
                    if (smp && sda_in) ack_err <= 1'b1;
                    // ack_err was cleared on start, so here it reflects only the address ACK slot.
                    if (last) begin
                        if (ack_err) begin
                            sda_en <= 1'b1;
                            sda_out <= 1'b0;
                            state <= STOP;
                        end else if (rw_l) begin
                            state <= READ_DATA;
                        end else begin
                            tx <= din_l;
                            state <= WRITE_DATA;
                        end
                    end
                end
                DATA_ACK, MASTER_NACK: begin
                    if (q_end) sda_en <= 1'b0;
                    if (state == DATA_ACK && smp && sda_in) ack_err <= 1'b1;
                    if (last) begin
                        sda_en <= 1'b1;
                        sda_out <= 1'b0;
                        state <= STOP;
                    end
                end
                READ_DATA: begin
                    if (q_end) sda_en <= 1'b0;
                    if (smp) rx <= {rx[6:0], sda_in};
                    if (last) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            dout <= rx;
                            state <= MASTER_NACK;
                        end
                    end
                end
                STOP: begin
                    if (t_end) begin
                        sda_en <= 1'b0;
                        sda_out <= 1'b1;
                    end
                    if (last) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: table-driven bench with a bus-level slave model and a byte scoreboard
module tb_i2c_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] din = '0;
    logic scl, sda_en, sda_out, busy, ack_err, done;
    logic [7:0] dout;
    logic slv_low = 1'b0;
    logic sda_bus;

    assign sda_bus = !((sda_en && !sda_out) || slv_low);

    always #4 clk = ~clk;

    i2c_master dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rw(rw),
        .addr(addr),
        .din(din),
        .sda_in(sda_bus),
        .scl(scl),
        .sda_en(sda_en),
        .sda_out(sda_out),
        .dout(dout),
        .busy(busy),
        .ack_err(ack_err),
        .done(done)
    );

    typedef struct {
        logic [6:0] addr;
        logic rw;
        logic [7:0] din;
        logic [7:0] rd;
        logic ack_a;
        logic ack_d;
        int nb;
        logic [8:0] e0;
        logic [8:0] e1;
        logic err;
        logic [7:0] dout;
        int lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    logic cur_rw = 1'b0;
    logic cur_ack_a = 1'b1;
    logic cur_ack_d = 1'b1;
    logic [7:0] cur_rd = '0;

    logic [8:0] obs[64];
    int obs_n = 0;
    int stops = 0;
    logic scl_q = 1'b1;
    logic sda_q = 1'b1;
    logic sda_now;
    logic in_txn = 1'b0;
    int bitn = 0;
    int byte_i = 0;
    logic [8:0] sh = '0;

    // Slave model and bus monitor: each observed byte is recorded with the level of its 9th (ack) bit.
    always @(negedge clk) begin
        sda_now = sda_bus;
        if (scl_q && scl && sda_q && !sda_now) begin
            in_txn = 1'b1;
            bitn = 0;
            byte_i = 0;
            slv_low = 1'b0;
        end else if (scl_q && scl && !sda_q && sda_now) begin
            if (in_txn) stops++;
            in_txn = 1'b0;
            slv_low = 1'b0;
        end else if (in_txn && !scl_q && scl) begin
            sh = {sh[7:0], sda_now};
            bitn++;
            if (bitn == 9) begin
                if (obs_n < 64) obs[obs_n] = sh;
                obs_n++;
                bitn = 0;
                byte_i++;
            end
        end else if (in_txn && scl_q && !scl) begin
            if (bitn == 8) slv_low = (byte_i == 0) ? cur_ack_a : (!cur_rw && cur_ack_d);
            else if (byte_i == 1 && cur_rw && cur_ack_a) slv_low = !cur_rd[7-bitn];
            else slv_low = 1'b0;
        end
        scl_q = scl;
        sda_q = sda_now;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [6:0] a, logic r, logic [7:0] d, logic [7:0] rd, logic aa, logic ad,
                                int nb, logic [8:0] e0, logic [8:0] e1, logic err, logic [7:0] dou, int lat);
        vec_t v;
        v.addr = a; v.rw = r; v.din = d; v.rd = rd; v.ack_a = aa; v.ack_d = ad;
        v.nb = nb; v.e0 = e0; v.e1 = e1; v.err = err; v.dout = dou; v.lat = lat;
        return v;
    endfunction

    task automatic set_slave(input vec_t v);
        cur_rw = v.rw;
        cur_ack_a = v.ack_a;
        cur_ack_d = v.ack_d;
        cur_rd = v.rd;
    endtask

    task automatic run_txn(input vec_t v, input bit poke);
        int k;
        int o0;
        int s0;
        bit busy_ok;
        set_slave(v);
        o0 = obs_n;
        s0 = stops;
        exp_q.push_back(v.e0);
        if (v.nb == 2) exp_q.push_back(v.e1);
        @(negedge clk);
        addr = v.addr; rw = v.rw; din = v.din; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ack_err_cleared", ack_err, 1'b0);
        k = 1;
        busy_ok = 1'b1;
        while (!done && k < 9000) begin
            if (!busy) busy_ok = 1'b0;
            start = poke && k == 500;
            if (start) begin
                addr = ~v.addr; rw = ~v.rw; din = ~v.din;
            end
            @(negedge clk);
            k++;
        end
        start = poke;
        chk("done_latency", k, v.lat);
        chk("busy_span", busy_ok, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("ack_err", ack_err, v.err);
        chk("dout", dout, v.dout);
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
        chk("stop_seen", stops - s0, 1);
        chk("byte_count", obs_n - o0, v.nb);
        for (int i = o0; i < obs_n && i < 64; i++)
            if (exp_q.size() != 0) chk($sformatf("bus_byte%0d", i - o0), obs[i], exp_q.pop_front());
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("still_idle", busy, 1'b0);
    endtask

    vec_t tbl[6];
    vec_t pv;

    initial begin
        tbl[0] = mk(7'h2A, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 2, {8'h54, 1'b0}, {8'hA5, 1'b0}, 1'b0, 8'h00, 8001);
        tbl[1] = mk(7'h15, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1, 2, {8'h2B, 1'b0}, {8'h3C, 1'b1}, 1'b0, 8'h3C, 8001);
        tbl[2] = mk(7'h33, 1'b0, 8'h77, 8'h00, 1'b0, 1'b1, 1, {8'h66, 1'b1}, 9'h000, 1'b1, 8'h3C, 4401);
        tbl[3] = mk(7'h50, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0, 2, {8'hA0, 1'b0}, {8'h81, 1'b1}, 1'b1, 8'h3C, 8001);
        tbl[4] = mk(7'h7F, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2, {8'hFE, 1'b0}, {8'h00, 1'b0}, 1'b0, 8'h3C, 8001);
        tbl[5] = mk(7'h4E, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b1, 2, {8'h9D, 1'b0}, {8'hC3, 1'b1}, 1'b0, 8'hC3, 8001);

        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda_en", sda_en, 1'b0);
        chk("rst_sda_out", sda_out, 1'b1);
        chk("rst_dout", dout, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tbl[i], 1'b0);

        pv = tbl[0];
        pv.dout = 8'hC3;
        run_txn(pv, 1'b1);

        set_slave(tbl[0]);
        @(negedge clk);
        addr = 7'h2A; rw = 1'b0; din = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1350) @(negedge clk);
        chk("pre_rst_scl_low", scl, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_scl", scl, 1'b1);
        chk("abort_sda_en", sda_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_dout", dout, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_txn(tbl[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
